// File: rtl/register_file.sv
// ARMv8 integer register file: X0..X30 in flops, X31 (XZR) hardwired to zero.
// Two combinational read ports, one synchronous write port, synchronous reset.
module register_file #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rn,
  input  logic [ADDR_WIDTH-1:0] rm,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  wr,
  output logic [DATA_WIDTH-1:0] data1,
  output logic [DATA_WIDTH-1:0] data2
);

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int STORED  = DEPTH - 1;

  logic [DATA_WIDTH-1:0] regs_q [STORED];
  logic [DATA_WIDTH-1:0] regs_d [STORED];

  // Only indices 0..STORED-1 have storage, so a write to XZR matches nothing.
  always_comb begin
    for (int i = 0; i < STORED; i++) begin
      regs_d[i] = regs_q[i];
      if (wr && (rd == ADDR_WIDTH'(i))) begin
        regs_d[i] = d;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STORED; i++) begin
      if (reset) begin
        regs_q[i] <= '0;
      end else begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read muxes default to zero, which is exactly the XZR value for index 31.
  always_comb begin
    data1 = '0;
    data2 = '0;
    for (int i = 0; i < STORED; i++) begin
      if (rn == ADDR_WIDTH'(i)) begin
        data1 = regs_q[i];
      end
      if (rm == ADDR_WIDTH'(i)) begin
        data2 = regs_q[i];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by random
// traffic, all checked against a simple array model of the architectural registers.
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [4:0]  rd;
  logic [63:0] d;
  logic        wr;
  logic [63:0] data1;
  logic [63:0] data2;

  int checkCount = 0;
  int failCount  = 0;

  logic [63:0] model [32];

  register_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .rn    (rn),
    .rm    (rm),
    .rd    (rd),
    .d     (d),
    .wr    (wr),
    .data1 (data1),
    .data2 (data2)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] modelRead(input logic [4:0] idx);
    if (idx == 5'd31) return 64'd0;
    return model[idx];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkReads(input string tag);
    #1;
    checkOutput({tag, " data1"}, data1, modelRead(rn));
    checkOutput({tag, " data2"}, data2, modelRead(rm));
  endtask

  // Drives one cycle's inputs, takes the rising edge, updates the model by the
  // architectural rules and leaves time 1ns after the edge.
  task automatic applyStimulus(input logic r, input logic w, input logic [4:0] a,
                               input logic [63:0] v, input logic [4:0] p1, input logic [4:0] p2);
    reset = r;
    wr    = w;
    rd    = a;
    d     = v;
    rn    = p1;
    rm    = p2;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
    end else if (w && a != 5'd31) begin
      model[a] = v;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0;
    wr    = 1'b0;
    rd    = '0;
    d     = '0;
    rn    = '0;
    rm    = '0;
    @(posedge clk);
    #1;

    // Reset beats a simultaneous write.
    applyStimulus(1'b1, 1'b1, 5'd0, 64'hD, 5'd0, 5'd1);
    checkOutput("reset x0", data1, 64'd0);
    checkOutput("reset x1", data2, 64'd0);

    applyStimulus(1'b0, 1'b1, 5'd0, 64'hD, 5'd0, 5'd1);
    checkOutput("write x0", data1, 64'hD);
    checkOutput("x1 untouched", data2, 64'd0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 64'hFFFFFFFFFFFFFFF2, 5'd0, 5'd1);
      checkOutput("wr0 hold", data1, 64'hD);
    end
    applyStimulus(1'b0, 1'b1, 5'd0, 64'hFFFFFFFFFFFFFFF2, 5'd0, 5'd1);
    checkOutput("write inverted", data1, 64'hFFFFFFFFFFFFFFF2);

    applyStimulus(1'b0, 1'b1, 5'd31, 64'hDEADBEEF, 5'd31, 5'd0);
    checkOutput("xzr read", data1, 64'd0);
    wr = 1'b0;
    for (int i = 0; i < 31; i++) begin
      rm = 5'(i);
      #1;
      checkOutput("xzr scan", data2, (i == 0) ? 64'hFFFFFFFFFFFFFFF2 : 64'd0);
    end

    applyStimulus(1'b0, 1'b1, 5'd5, 64'h1234, 5'd5, 5'd30);
    applyStimulus(1'b0, 1'b1, 5'd30, 64'hFFFF0000FFFF0000, 5'd5, 5'd30);
    checkOutput("x5", data1, 64'h1234);
    checkOutput("x30", data2, 64'hFFFF0000FFFF0000);
    wr = 1'b0;
    rn = 5'd30;
    #1;
    checkOutput("same idx p1", data1, 64'hFFFF0000FFFF0000);
    checkOutput("same idx p2", data2, 64'hFFFF0000FFFF0000);

    for (int i = 0; i < 31; i++) begin
      applyStimulus(1'b0, 1'b1, 5'(i), {32'hA5A50000 + 32'(i), 32'(i * 7 + 1)}, 5'(i), 5'd31);
      checkOutput("fill", data1, {32'hA5A50000 + 32'(i), 32'(i * 7 + 1)});
    end
    applyStimulus(1'b1, 1'b1, 5'd3, 64'h3333, 5'd0, 5'd0);
    wr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rn = 5'(i);
      rm = 5'(31 - i);
      #1;
      checkOutput("post reset p1", data1, 64'd0);
      checkOutput("post reset p2", data2, 64'd0);
    end
    applyStimulus(1'b0, 1'b1, 5'd7, 64'h7777, 5'd7, 5'd3);
    checkOutput("write after reset", data1, 64'h7777);
    checkOutput("reset write lost", data2, 64'd0);

    // Random traffic: reads are checked before the edge (old contents) and after it.
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 49) == 0);
      wr    = ($urandom_range(0, 3) != 0);
      rd    = 5'($urandom);
      d     = {$urandom, $urandom};
      rn    = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
      rm    = 5'($urandom);
      checkReads("pre edge");
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
      end else if (wr && rd != 5'd31) begin
        model[rd] = d;
      end
      checkReads("post edge");
      #2;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- ARMv8 general-purpose integer register file for the single-cycle datapath: 32 registers, 64 bits each.
- Two asynchronous read ports: rn supplies the first operand, rm the second.
- One synchronous write port, rd, written with d when wr is high.
- Index 31 is the zero register (XZR): always reads 0, writes are discarded.

Parameters:
- DATA_WIDTH, 64, width of each register and of the data ports.
- ADDR_WIDTH, 5, width of the register index ports; depth is 2**ADDR_WIDTH = 32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rn  input  ADDR_WIDTH  read index for port 1.
- rm  input  ADDR_WIDTH  read index for port 2.
- rd  input  ADDR_WIDTH  write index.
- d  input  DATA_WIDTH  write data.
- wr  input  1  write enable, active-high.
- data1  output  DATA_WIDTH  contents of register rn.
- data2  output  DATA_WIDTH  contents of register rm.

Behaviour:
- Storage: 32 x 64-bit registers, X0..X31.
  - X31 is not stored; it is hardwired zero.
- Reset:
  - On a rising clk edge with reset=1, X0..X30 are cleared to 0.
  - Reset has priority over a simultaneous write; the write is lost.
  - data1/data2 therefore read 0 for every index after reset.
  - Reset asserted while wr=1 mid-sequence clears everything on that edge. Normal writes resume on the first edge with reset=0.
- Write:
  - On a rising clk edge with reset=0, wr=1 and rd != 31: reg[rd] <= d.
  - wr=0: no register changes.
  - rd=31: write silently ignored.
  - No partial writes; all 64 bits are written.
- Read:
  - Purely combinational, zero latency.
  - data1 = (rn==31) ? 0 : reg[rn].
  - data2 = (rm==31) ? 0 : reg[rm].
  - rn == rm is legal; both ports return the same value.
- Read-during-write: no internal bypass.
  - Before the edge, the read port returns the old contents.
  - Immediately after the edge, it returns the new value, because reads are combinational.
  - d changing while wr=1 between edges has no effect until the next rising edge.
- Outputs never go X after reset; before the first reset, contents are undefined except X31.
- Single clock domain; no handshake; one write per cycle maximum.

Test Plan:
- Reset with rn=0, rm=1, wr=1, rd=0, d=64'hD -> after the edge data1=0, data2=0 (reset beats write).
- reset=0, rd=0, d=64'h000000000000000D, wr=1, one clk edge -> data1 (rn=0) = 64'hD; data2 (rm=1) = 0 (unaffected).
- wr=0, d inverted to 64'hFFFFFFFFFFFFFFF2 across several edges -> data1 stays 64'hD. Then wr=1 for one edge -> data1 = 64'hFFFFFFFFFFFFFFF2.
- rd=31, d=64'hDEADBEEF, wr=1, edge; rn=31 -> data1=0. Scan rm over 0..30 -> no register modified.
- Write X5=64'h1234 and X30=64'hFFFF_0000_FFFF_0000 on consecutive edges; rn=5, rm=30 -> data1=64'h1234, data2=64'hFFFF0000FFFF0000. Set rn=rm=30 -> both outputs equal.
- Mid-sequence reset after writing X0..X30 with distinct values -> all reads 0 on the following cycle; a write in the next cycle (reset=0) is retained.
